// File: rtl/load_order_scheduler.sv
// load_order_scheduler: orders load issue in a circular instruction window.
// For each accepted load it walks every older window entry (commit_ptr up to the
// load's own entry), one entry per cycle. It stalls on any store whose address
// is still unknown. It grants the load once the walk reaches the load's entry and
// reports the youngest older store with a matching word address.
// Optional build macro LDSCHED_STALL_CNT_EN adds the stall_cycles output.
module load_order_scheduler #(
    parameter int ENTRY_W  = 5,
    parameter int ADDR_W   = 32,
    parameter int WORD_LSB = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] commit_ptr,
    input  logic               lw_req,
    output logic               lw_ready,
    input  logic [ENTRY_W-1:0] lw_entry,
    input  logic [ADDR_W-1:0]  lw_addr,
    output logic [ENTRY_W-1:0] scan_entry,
    input  logic               st_valid,
    input  logic               st_addr_known,
    input  logic [ADDR_W-1:0]  st_addr,
    output logic               lw_grant,
    output logic               lw_conflict,
    output logic [ENTRY_W-1:0] conflict_entry,
`ifdef LDSCHED_STALL_CNT_EN
    output logic [15:0]        stall_cycles,
`endif
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT} state_t;

    localparam int WORD_W = ADDR_W - WORD_LSB;

    state_t             state_reg, state_next;
    logic [ENTRY_W-1:0] load_entry_reg, load_entry_next;
    logic [WORD_W-1:0]  load_word_reg, load_word_next;
    logic               match_reg, match_next;
    logic [ENTRY_W-1:0] scan_entry_reg, scan_entry_next;
    logic [ENTRY_W-1:0] conflict_entry_reg, conflict_entry_next;

    logic at_load;
    logic word_match;
    logic accept;

    // Byte-offset bits take no part in the word compare.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{lw_addr[WORD_LSB-1:0], st_addr[WORD_LSB-1:0]};

    assign at_load    = (scan_entry_reg == load_entry_reg);
    assign word_match = (st_addr[ADDR_W-1:WORD_LSB] == load_word_reg);
    assign accept     = (state_reg == IDLE) && lw_req && !flush;

    assign lw_ready       = (state_reg == IDLE);
    assign busy           = (state_reg != IDLE);
    assign scan_entry     = scan_entry_reg;
    assign conflict_entry = conflict_entry_reg;
    // A flush in the grant cycle aborts the load, so it suppresses the grant.
    assign lw_grant       = (state_reg == SCAN) && at_load && !flush;
    assign lw_conflict    = lw_grant && match_reg;

    // Next-state logic: accept, walk the older entries, and stall on unknown store addresses.
    always_comb begin
        state_next          = state_reg;
        load_entry_next     = load_entry_reg;
        load_word_next      = load_word_reg;
        match_next          = match_reg;
        scan_entry_next     = scan_entry_reg;
        conflict_entry_next = conflict_entry_reg;
        if (flush) begin
            state_next = IDLE;
            match_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (lw_req) begin
                        state_next      = SCAN;
                        load_entry_next = lw_entry;
                        load_word_next  = lw_addr[ADDR_W-1:WORD_LSB];
                        scan_entry_next = commit_ptr;
                        match_next      = 1'b0;
                    end
                end
                SCAN: begin
                    if (at_load) begin
                        state_next = IDLE;
                    end else if (st_valid && !st_addr_known) begin
                        state_next = WAIT;
                    end else if (st_valid && word_match) begin
                        // Later matches overwrite earlier ones, so the youngest older store wins.
                        match_next          = 1'b1;
                        conflict_entry_next = scan_entry_reg;
                        scan_entry_next     = scan_entry_reg + 1'b1;
                    end else begin
                        scan_entry_next = scan_entry_reg + 1'b1;
                    end
                end
                WAIT: begin
                    // Go back to SCAN without advancing, so SCAN re-examines this entry.
                    if (!st_valid || st_addr_known) begin
                        state_next = SCAN;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= IDLE;
            load_entry_reg     <= '0;
            load_word_reg      <= '0;
            match_reg          <= 1'b0;
            scan_entry_reg     <= '0;
            conflict_entry_reg <= '0;
        end else begin
            state_reg          <= state_next;
            load_entry_reg     <= load_entry_next;
            load_word_reg      <= load_word_next;
            match_reg          <= match_next;
            scan_entry_reg     <= scan_entry_next;
            conflict_entry_reg <= conflict_entry_next;
        end
    end

`ifdef LDSCHED_STALL_CNT_EN
    logic [15:0] stall_cycles_reg;
    assign stall_cycles = stall_cycles_reg;

    // Saturating count of WAIT cycles for the current load. It holds after the grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_reg <= '0;
        end else if (accept) begin
            stall_cycles_reg <= '0;
        end else if (state_reg == WAIT && !flush && stall_cycles_reg != 16'hFFFF) begin
            stall_cycles_reg <= stall_cycles_reg + 16'd1;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_load_order_scheduler.sv
// Directed testbench for load_order_scheduler. The store table is modelled as
// arrays indexed combinationally by scan_entry. Define LDSCHED_STALL_CNT_EN
// to also check stall_cycles.
module tb_load_order_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [4:0]  commit_ptr;
    logic        lw_req;
    logic        lw_ready;
    logic [4:0]  lw_entry;
    logic [31:0] lw_addr;
    logic [4:0]  scan_entry;
    logic        st_valid;
    logic        st_addr_known;
    logic [31:0] st_addr;
    logic        lw_grant;
    logic        lw_conflict;
    logic [4:0]  conflict_entry;
    logic        busy;
`ifdef LDSCHED_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    logic        tbl_valid [32];
    logic        tbl_known [32];
    logic [31:0] tbl_addr  [32];

    int          checks = 0;
    int          errors = 0;
    int          grant_cyc;
    logic        got_conflict;
    logic [4:0]  got_centry;
    logic [4:0]  trace [64];

    always #5 clk = ~clk;

    assign st_valid      = tbl_valid[scan_entry];
    assign st_addr_known = tbl_known[scan_entry];
    assign st_addr       = tbl_addr[scan_entry];

    load_order_scheduler dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .commit_ptr     (commit_ptr),
        .lw_req         (lw_req),
        .lw_ready       (lw_ready),
        .lw_entry       (lw_entry),
        .lw_addr        (lw_addr),
        .scan_entry     (scan_entry),
        .st_valid       (st_valid),
        .st_addr_known  (st_addr_known),
        .st_addr        (st_addr),
        .lw_grant       (lw_grant),
        .lw_conflict    (lw_conflict),
        .conflict_entry (conflict_entry),
`ifdef LDSCHED_STALL_CNT_EN
        .stall_cycles   (stall_cycles),
`endif
        .busy           (busy)
    );

    task automatic clear_table();
        for (int i = 0; i < 32; i++) begin
            tbl_valid[i] = 1'b0;
            tbl_known[i] = 1'b1;
            tbl_addr[i]  = 32'h0;
        end
    endtask

    // Issues one load and follows it until the grant. Cycle 1 is the first cycle after the accept edge.
    // If rel_cyc is nonzero, the address of entry rel_entry becomes known at the start of that cycle.
    task automatic run_load(input logic [4:0] cp, input logic [4:0] ent, input logic [31:0] addr,
                            input int rel_cyc, input logic [4:0] rel_entry, input int max_cyc);
        @(negedge clk);
        commit_ptr = cp;
        lw_entry   = ent;
        lw_addr    = addr;
        lw_req     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lw_req       = 1'b0;
        grant_cyc    = -1;
        got_conflict = 1'bx;
        got_centry   = 5'bx;
        for (int c = 1; c <= max_cyc; c++) begin
            if (c == rel_cyc) tbl_known[rel_entry] = 1'b1;
            trace[c] = scan_entry;
            if (lw_grant === 1'b1) begin
                grant_cyc    = c;
                got_conflict = lw_conflict;
                got_centry   = conflict_entry;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++; if (lw_ready !== 1'b1) begin errors++; $display("FAIL reset_lw_ready got=%b exp=1", lw_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (lw_grant !== 1'b0 || lw_conflict !== 1'b0) begin errors++; $display("FAIL reset_grant got=%b/%b exp=0/0", lw_grant, lw_conflict); end
        checks++; if (scan_entry !== 5'd0 || conflict_entry !== 5'd0) begin errors++; $display("FAIL reset_entries got=%0d/%0d exp=0/0", scan_entry, conflict_entry); end
`ifdef LDSCHED_STALL_CNT_EN
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
`endif
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        $display("test_reset: done");
    endtask

    task automatic test_oldest();
        clear_table();
        run_load(5'd7, 5'd7, 32'h40, 0, 5'd0, 10);
        checks++; if (grant_cyc !== 1) begin errors++; $display("FAIL oldest_latency got=%0d exp=1", grant_cyc); end
        checks++; if (got_conflict !== 1'b0) begin errors++; $display("FAIL oldest_conflict got=%b exp=0", got_conflict); end
        $display("test_oldest: grant at accept+%0d", grant_cyc);
    endtask

    task automatic test_no_stores();
        clear_table();
        run_load(5'd3, 5'd8, 32'h80, 0, 5'd0, 20);
        checks++; if (grant_cyc !== 6) begin errors++; $display("FAIL nostore_latency got=%0d exp=6", grant_cyc); end
        checks++; if (got_conflict !== 1'b0) begin errors++; $display("FAIL nostore_conflict got=%b exp=0", got_conflict); end
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (trace[c] !== 5'(c + 2)) begin errors++; $display("FAIL nostore_scan c=%0d got=%0d exp=%0d", c, trace[c], c + 2); end
        end
        $display("test_no_stores: grant at accept+%0d", grant_cyc);
    endtask

    task automatic test_wrap_matches();
        clear_table();
        tbl_valid[31] = 1'b1; tbl_addr[31] = 32'h1002;
        tbl_valid[0]  = 1'b1; tbl_addr[0]  = 32'h1004;
        tbl_valid[1]  = 1'b1; tbl_addr[1]  = 32'h1003;
        run_load(5'd30, 5'd2, 32'h1000, 0, 5'd0, 20);
        checks++; if (grant_cyc !== 5) begin errors++; $display("FAIL wrap_latency got=%0d exp=5", grant_cyc); end
        checks++; if (got_conflict !== 1'b1) begin errors++; $display("FAIL wrap_conflict got=%b exp=1", got_conflict); end
        checks++; if (got_centry !== 5'd1) begin errors++; $display("FAIL wrap_centry got=%0d exp=1", got_centry); end
        checks++; if (trace[3] !== 5'd0) begin errors++; $display("FAIL wrap_scan_wrap got=%0d exp=0", trace[3]); end
        @(negedge clk);
        checks++; if (lw_conflict !== 1'b0 || lw_grant !== 1'b0) begin errors++; $display("FAIL wrap_after_grant got=%b/%b exp=0/0", lw_grant, lw_conflict); end
        checks++; if (conflict_entry !== 5'd1) begin errors++; $display("FAIL wrap_centry_hold got=%0d exp=1", conflict_entry); end
        $display("test_wrap_matches: grant at accept+%0d conflict_entry=%0d", grant_cyc, got_centry);
    endtask

    task automatic test_unknown_addr();
        clear_table();
        tbl_valid[4] = 1'b1; tbl_known[4] = 1'b0; tbl_addr[4] = 32'h2000;
        run_load(5'd2, 5'd6, 32'h3000, 6, 5'd4, 40);
        checks++; if (grant_cyc !== 9) begin errors++; $display("FAIL wait_latency got=%0d exp=9", grant_cyc); end
        checks++; if (got_conflict !== 1'b0) begin errors++; $display("FAIL wait_conflict got=%b exp=0", got_conflict); end
        for (int c = 3; c <= 7; c++) begin
            checks++;
            if (trace[c] !== 5'd4) begin errors++; $display("FAIL wait_scan_hold c=%0d got=%0d exp=4", c, trace[c]); end
        end
        checks++; if (got_centry !== 5'd1) begin errors++; $display("FAIL wait_centry_hold got=%0d exp=1", got_centry); end
`ifdef LDSCHED_STALL_CNT_EN
        @(negedge clk);
        checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL wait_stall_cycles got=%0d exp=3", stall_cycles); end
`endif
        $display("test_unknown_addr: grant at accept+%0d", grant_cyc);
    endtask

    task automatic test_max_distance();
        clear_table();
        run_load(5'd5, 5'd4, 32'h100, 0, 5'd0, 40);
        checks++; if (grant_cyc !== 32) begin errors++; $display("FAIL maxdist_latency got=%0d exp=32", grant_cyc); end
        $display("test_max_distance: grant at accept+%0d", grant_cyc);
    endtask

    task automatic test_flush();
        int grants_seen;
        clear_table();
        // Flush in the middle of a SCAN.
        @(negedge clk);
        commit_ptr = 5'd3; lw_entry = 5'd20; lw_addr = 32'h500; lw_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lw_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1 || lw_ready !== 1'b0) begin errors++; $display("FAIL flush_scan_busy got=%b/%b exp=1/0", busy, lw_ready); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || lw_ready !== 1'b1) begin errors++; $display("FAIL flush_scan_idle got=%b/%b exp=0/1", busy, lw_ready); end
        grants_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (lw_grant === 1'b1) grants_seen++;
        end
        checks++; if (grants_seen !== 0) begin errors++; $display("FAIL flush_no_grant got=%0d exp=0", grants_seen); end
        // Flush while stalled in WAIT.
        tbl_valid[5] = 1'b1; tbl_known[5] = 1'b0;
        commit_ptr = 5'd4; lw_entry = 5'd9; lw_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lw_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (scan_entry !== 5'd5 || busy !== 1'b1) begin errors++; $display("FAIL flush_wait_held got=%0d/%b exp=5/1", scan_entry, busy); end
        flush = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || lw_ready !== 1'b1) begin errors++; $display("FAIL flush_wait_idle got=%b/%b exp=0/1", busy, lw_ready); end
        // A request together with flush is not accepted.
        lw_req = 1'b1;
        @(negedge clk);
        flush = 1'b0; lw_req = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept got=%b exp=0", busy); end
        clear_table();
        run_load(5'd10, 5'd12, 32'h600, 0, 5'd0, 10);
        checks++; if (grant_cyc !== 3) begin errors++; $display("FAIL flush_reload_latency got=%0d exp=3", grant_cyc); end
        $display("test_flush: reload grant at accept+%0d", grant_cyc);
    endtask

    task automatic test_async_reset();
        clear_table();
        tbl_valid[1] = 1'b1; tbl_addr[1] = 32'h700;
        @(negedge clk);
        commit_ptr = 5'd0; lw_entry = 5'd25; lw_addr = 32'h700; lw_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lw_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (conflict_entry !== 5'd1) begin errors++; $display("FAIL areset_pre_match got=%0d exp=1", conflict_entry); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || lw_ready !== 1'b1) begin errors++; $display("FAIL areset_state got=%b/%b exp=0/1", busy, lw_ready); end
        checks++; if (scan_entry !== 5'd0 || conflict_entry !== 5'd0) begin errors++; $display("FAIL areset_entries got=%0d/%0d exp=0/0", scan_entry, conflict_entry); end
        checks++; if (lw_grant !== 1'b0 || lw_conflict !== 1'b0) begin errors++; $display("FAIL areset_grant got=%b/%b exp=0/0", lw_grant, lw_conflict); end
        @(negedge clk);
        reset_n = 1'b1;
        clear_table();
        run_load(5'd9, 5'd9, 32'h10, 0, 5'd0, 10);
        checks++; if (grant_cyc !== 1 || got_conflict !== 1'b0) begin errors++; $display("FAIL areset_reload got=%0d/%b exp=1/0", grant_cyc, got_conflict); end
        $display("test_async_reset: reload grant at accept+%0d", grant_cyc);
    endtask

    initial begin
        flush = 1'b0; lw_req = 1'b0; commit_ptr = '0; lw_entry = '0; lw_addr = '0;
        clear_table();
        test_reset();
        test_oldest();
        test_no_stores();
        test_wrap_matches();
        test_unknown_addr();
        test_max_distance();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_order_scheduler.md
Name: load_order_scheduler

Overview:
- Sequences load issue in the 32-entry circular instruction window.
- For each accepted load, walks every older entry from commit_ptr up to the load's entry, one entry per cycle, and inspects the store-table lookup for that entry.
- Grants the load once all older stores have known addresses. Reports the youngest older store whose word address matches, so the LSU can forward from it or replay.
- Sits between the load issue logic and the store table; the store table answers scan_entry combinationally.

Parameters:
- ENTRY_W, 5: window index width; window depth is 2^ENTRY_W and wraps naturally.
- ADDR_W, 32: address width.
- WORD_LSB, 2: low address bits ignored in the match compare; the compare uses addr[ADDR_W-1:WORD_LSB].

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; aborts the current load.
- commit_ptr  in  ENTRY_W  oldest uncommitted entry; sampled at accept.
- lw_req  in  1  load request valid.
- lw_ready  out  1  scheduler can accept a load.
- lw_entry  in  ENTRY_W  window entry of the load.
- lw_addr  in  ADDR_W  load address.
- scan_entry  out  ENTRY_W  entry currently examined.
- st_valid  in  1  scan_entry holds an uncommitted store (combinational from the store table).
- st_addr_known  in  1  that store's address is resolved.
- st_addr  in  ADDR_W  that store's address.
- lw_grant  out  1  one-cycle pulse: load may issue.
- lw_conflict  out  1  valid with lw_grant: an older matching store exists.
- conflict_entry  out  ENTRY_W  youngest older matching store; valid with lw_conflict.
- busy  out  1  a load is being processed.

Behaviour:
- Reset (async, reset_n=0) values:
  - state=IDLE, lw_ready=1, busy=0.
  - lw_grant=0, lw_conflict=0.
  - scan_entry=0, conflict_entry=0.
  - Internal captured load entry, load address and match flag all cleared.
- Accept:
  - Occurs in IDLE when lw_req=1 and flush=0.
  - Registers lw_entry, lw_addr and scan_entry<=commit_ptr; clears the match flag; moves to SCAN.
  - lw_ready = (state==IDLE), combinational.
- SCAN, each cycle:
  - scan_entry==captured lw_entry: assert lw_grant for this cycle. lw_conflict = match flag; conflict_entry holds the last match. Next state is IDLE.
  - Else st_valid=1 and st_addr_known=0: go to WAIT; scan_entry holds.
  - Else st_valid=1 and word addresses equal: set the match flag, conflict_entry<=scan_entry, scan_entry<=scan_entry+1 (mod 2^ENTRY_W).
  - Else: scan_entry<=scan_entry+1.
- WAIT, each cycle: re-evaluate the same entry.
  - st_valid=0, or st_valid=1 with st_addr_known=1: return to SCAN; scan_entry is not advanced and is re-examined there.
  - Otherwise stay in WAIT.
- Latency: N = (lw_entry - commit_ptr) mod 2^ENTRY_W older entries with no WAIT cycles gives lw_grant at accept+1+N.
  - N=0 (load is oldest): grant at accept+1.
  - Maximum N is 31.
- Ordering: the scan runs oldest to youngest, so the last match is the youngest older store; later matches overwrite conflict_entry.
- Wrap-around: scan_entry increments with natural ENTRY_W-bit wrap (31 to 0); no special case is needed.
- commit_ptr moving during a scan is ignored. Stores that have already committed are still compared, which is conservative and correct.
- flush=1 in any state:
  - next edge: state=IDLE, no lw_grant, match flag cleared.
  - Has priority over accept and over grant in the same cycle.
- busy = (state!=IDLE).
- lw_conflict and lw_grant are registered-state decodes, 0 outside the grant cycle. conflict_entry holds its value until the next match or reset.
- lw_req asserted while busy is ignored. The requester must hold its request until lw_ready=1.
- Reset asserted mid-scan returns the block immediately to the reset values above.

Optional Feature:
- Macro LDSCHED_STALL_CNT_EN.
- When defined:
  - Adds output stall_cycles [15:0]: saturating count of WAIT cycles for the current load.
  - Cleared at accept and on reset; holds its value after grant until the next accept.
  - Saturates at 16'hFFFF.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Oldest load: commit_ptr=7, lw_entry=7, lw_req pulse -> lw_grant at accept+1, lw_conflict=0.
- No stores: commit_ptr=3, lw_entry=8, st_valid=0 -> scan_entry steps 3,4,5,6,7,8; lw_grant at accept+6, lw_conflict=0.
- Wrap with two matches:
  - Setup: commit_ptr=30, lw_entry=2, lw_addr=0x1000. Stores at 31 (addr 0x1002) and at 1 (addr 0x1003).
  - Expected: lw_grant at accept+5, lw_conflict=1, conflict_entry=1.
- Unknown store address: store at entry 4 with st_addr_known=0 for 3 cycles, then known with non-matching address, on a scan 2 to 6.
  - Expected: scan_entry held at 4 during WAIT; lw_grant at accept+1+4+3+1; lw_conflict=0.
  - With the macro defined: stall_cycles=3.
- Flush: assert flush mid-scan or during WAIT -> no lw_grant, lw_ready=1 next cycle, and a new load is accepted cleanly.
- Async reset: drop reset_n mid-scan with no clock edge -> outputs go to reset values immediately.
